// File: rtl/alu_coproc.sv
// alu_coproc: multi-cycle ALU coprocessor that fetches operands over a
// shared register bus and returns a result with carry/zero flags.
module alu_coproc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             oe_n,
    output logic [3:0]       bus_req,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;

    localparam logic [3:0] REQ_NONE = 4'b0000;
    localparam logic [3:0] REQ_PRES = 4'b0001;
    localparam logic [3:0] REQ_ADV  = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_A,
        S_GET_A,
        S_ADV,
        S_REQ_B,
        S_GET_B,
        S_EXEC,
        S_WB
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   alu_r;
    logic             op_valid;
    logic             op_imm;
    logic             op_unary;

    always_comb begin
        op_valid = (opcode >= OP_ADDI) && (opcode <= OP_SHR);
        op_imm   = (opcode == OP_ADDI) || (opcode == OP_SUBI);
        op_unary = (op_q == OP_SHL) || (op_q == OP_SHR);
    end

    // Bit WIDTH of alu_r is the carry/borrow/shifted-out flag.
    always_comb begin
        alu_r = '0;
        unique case (op_q)
            OP_ADDI,
            OP_ADD:  alu_r = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu_r = {1'b0, a_q} - {1'b0, b_q};
            OP_SUBI: alu_r = {1'b0, b_q} - {1'b0, a_q};
            OP_AND:  alu_r = {1'b0, a_q & b_q};
            OP_OR:   alu_r = {1'b0, a_q | b_q};
            OP_XOR:  alu_r = {1'b0, a_q ^ b_q};
            OP_SHL:  alu_r = {a_q, 1'b0};
            OP_SHR:  alu_r = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bus_req <= REQ_NONE;
            bus_out <= '0;
            bus_oe  <= 1'b0;
            done    <= 1'b0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q <= opcode;
                        busy <= 1'b1;
                        if (op_imm) begin
                            a_q     <= imm_in;
                            bus_req <= REQ_ADV;
                            state   <= S_ADV;
                        end else begin
                            bus_req <= REQ_PRES;
                            state   <= S_REQ_A;
                        end
                    end
                end
                S_REQ_A: begin
                    bus_req <= op_unary ? REQ_NONE : REQ_ADV;
                    state   <= S_GET_A;
                end
                S_GET_A: begin
                    a_q <= bus_in;
                    if (op_unary) begin
                        state <= S_EXEC;
                    end else begin
                        bus_req <= REQ_PRES;
                        state   <= S_REQ_B;
                    end
                end
                S_ADV: begin
                    bus_req <= REQ_PRES;
                    state   <= S_REQ_B;
                end
                S_REQ_B: begin
                    bus_req <= REQ_NONE;
                    state   <= S_GET_B;
                end
                S_GET_B: begin
                    b_q   <= bus_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    carry  <= alu_r[WIDTH];
                    zero   <= (alu_r[WIDTH-1:0] == '0);
                    done   <= 1'b1;
                    bus_oe <= ~oe_n;
                    if (!oe_n) begin
                        bus_out <= alu_r[WIDTH-1:0];
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    done   <= 1'b0;
                    bus_oe <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_coproc.sv
// tb_alu_coproc: table-driven, hand-sequenced and randomized checks of
// alu_coproc against a plain-arithmetic reference model.
module tb_alu_coproc;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   opcode;
    logic [W-1:0] imm_in;
    logic [W-1:0] bus_in;
    logic         oe_n;
    logic [3:0]   bus_req;
    logic [W-1:0] bus_out;
    logic         bus_oe;
    logic         done;
    logic         carry;
    logic         zero;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] ref_last = 4'h0;

    alu_coproc #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .imm_in  (imm_in),
        .bus_in  (bus_in),
        .oe_n    (oe_n),
        .bus_req (bus_req),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .done    (done),
        .carry   (carry),
        .zero    (zero),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] r0;
        logic [3:0] r1;
        logic       oe_n;
        logic [3:0] e_out;
        logic       e_cy;
        logic       e_z;
        int         e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        else
            n_pass++;
    endtask

    // Expected bus_req codes per cycle from cycle 1 up to the done cycle.
    function automatic logic [63:0] seq_of(input int lat);
        if (lat == 6) return 64'h131000;
        if (lat == 5) return 64'h31000;
        return 64'h1000;
    endfunction

    function automatic void model(input logic [3:0] op, imm, r0, r1,
                                  output logic [3:0] res,
                                  output logic cy, z,
                                  output int lat);
        int a, b, r, m;
        m = 1 << W;
        a = int'(r0);
        b = int'(r1);
        r = 0;
        cy = 1'b0;
        lat = 6;
        case (op)
            4'd1: begin r = int'(imm) + a; cy = (r >= m); lat = 5; end
            4'd2: begin r = a + b; cy = (r >= m); end
            4'd3: begin r = a - int'(imm); cy = (a < int'(imm)); lat = 5; end
            4'd4: begin r = a - b; cy = (a < b); end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: begin r = a * 2; cy = (a >= m / 2); lat = 4; end
            4'd9: begin r = a / 2; cy = (a % 2 == 1); lat = 4; end
            default: r = 0;
        endcase
        res = r[3:0];
        z = (res == 4'h0);
    endfunction

    // Issues one op at the next edge, plays the register bus, and
    // reports what was seen during the done cycle and the cycle after.
    task automatic run_op(input logic [3:0] op, imm, r0, r1,
                          input logic oe_v, input int exec_cyc,
                          input bit scr, input int chg_cyc,
                          input logic [3:0] chg_op,
                          output int d_cyc, output logic [3:0] g_out,
                          output logic g_oe, g_cy, g_z,
                          output logic [63:0] g_seq,
                          output logic g_post);
        int idx;
        logic [3:0] regs[2];
        regs[0] = r0;
        regs[1] = r1;
        idx = 0;
        d_cyc = -1;
        g_out = 0; g_oe = 0; g_cy = 0; g_z = 0;
        g_seq = 0;
        opcode = op;
        imm_in = imm;
        oe_n = oe_v;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            if (scr) begin
                opcode = 4'($urandom);
                imm_in = 4'($urandom);
                oe_n = (c == exec_cyc) ? oe_v : 1'($urandom);
            end
            if (c == chg_cyc) opcode = chg_op;
            if (c <= 8) g_seq = {g_seq[59:0], bus_req};
            if (bus_req == 4'b0001) begin
                bus_in = (idx < 2) ? regs[idx] : 4'h0;
                idx++;
            end
            if (done) begin
                d_cyc = c;
                g_out = bus_out;
                g_oe = bus_oe;
                g_cy = carry;
                g_z = zero;
                break;
            end
            @(posedge clk); #1;
        end
        opcode = 4'h0;
        oe_n = 1'b1;
        @(posedge clk); #1;
        g_post = !done && !bus_oe && !busy && (bus_out == g_out);
    endtask

    task automatic check_op(input string tag, input int d_cyc, e_lat,
                            input logic [3:0] g_out, e_out,
                            input logic g_oe, e_oe, g_cy, e_cy, g_z, e_z,
                            input logic [63:0] g_seq, input logic g_post);
        chk({tag, " lat"}, d_cyc, e_lat);
        chk({tag, " out"}, g_out, e_out);
        chk({tag, " oe"}, g_oe, e_oe);
        chk({tag, " carry"}, g_cy, e_cy);
        chk({tag, " zero"}, g_z, e_z);
        chk({tag, " req"}, g_seq, seq_of(e_lat));
        chk({tag, " post"}, g_post, 1'b1);
    endtask

    initial begin
        vec_t tbl[10];
        int d, lat;
        logic [3:0] go, eo;
        logic goe, gc, gz, gp, ec, ez, bad;
        logic [63:0] gs;

        tbl[0] = '{4'd2, 4'h0, 4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b0, 6};
        tbl[1] = '{4'd3, 4'h3, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5};
        tbl[2] = '{4'd3, 4'h3, 4'h2, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 5};
        tbl[3] = '{4'd9, 4'h0, 4'h5, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4};
        tbl[4] = '{4'd7, 4'h0, 4'hA, 4'hF, 1'b0, 4'h5, 1'b0, 1'b0, 6};
        tbl[5] = '{4'd8, 4'h0, 4'h9, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4};
        tbl[6] = '{4'd5, 4'h0, 4'hC, 4'h3, 1'b1, 4'h2, 1'b0, 1'b1, 6};
        tbl[7] = '{4'd4, 4'h0, 4'h5, 4'h7, 1'b0, 4'hE, 1'b1, 1'b0, 6};
        tbl[8] = '{4'd6, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 6};
        tbl[9] = '{4'd1, 4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 5};

        rst_n = 1'b0;
        opcode = 4'h0;
        imm_in = 4'h0;
        bus_in = 4'h0;
        oe_n = 1'b0;
        #12;
        chk("reset", {bus_req, bus_out, bus_oe, done, carry, zero, busy},
            13'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].imm, tbl[i].r0, tbl[i].r1,
                   tbl[i].oe_n, tbl[i].e_lat - 1, 1'b0, 0, 4'h0,
                   d, go, goe, gc, gz, gs, gp);
            check_op($sformatf("tbl%0d", i), d, tbl[i].e_lat, go,
                     tbl[i].e_out, goe, !tbl[i].oe_n, gc, tbl[i].e_cy,
                     gz, tbl[i].e_z, gs, gp);
            if (!tbl[i].oe_n) ref_last = tbl[i].e_out;
        end

        // opcode switched from ADD to AND during REQ_B
        model(4'd2, 4'h0, 4'h9, 4'h3, eo, ec, ez, lat);
        run_op(4'd2, 4'h0, 4'h9, 4'h3, 1'b0, lat - 1, 1'b0, 3, 4'd5,
               d, go, goe, gc, gz, gs, gp);
        check_op("chg", d, lat, go, eo, goe, 1'b1, gc, ec, gz, ez, gs, gp);
        ref_last = eo;

        opcode = 4'd12;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bad = bad | busy | done | (bus_req != 4'h0);
        end
        opcode = 4'h0;
        chk("nop12", bad, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op, im, r0, r1;
            logic oe;
            op = 4'($urandom_range(1, 9));
            im = 4'($urandom);
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            oe = ($urandom_range(0, 3) == 0);
            model(op, im, r0, r1, eo, ec, ez, lat);
            if (oe) eo = ref_last;
            run_op(op, im, r0, r1, oe, lat - 1, 1'b1, 0, 4'h0,
                   d, go, goe, gc, gz, gs, gp);
            check_op($sformatf("rnd%0d op%0d", i, op), d, lat, go, eo,
                     goe, !oe, gc, ec, gz, ez, gs, gp);
            ref_last = eo;
        end

        // leave carry and bus_out nonzero before the mid-op reset
        run_op(4'd2, 4'h0, 4'h9, 4'h8, 1'b0, 5, 1'b0, 0, 4'h0,
               d, go, goe, gc, gz, gs, gp);
        check_op("pre", d, 6, go, 4'h1, goe, 1'b1, gc, 1'b1, gz, 1'b0,
                 gs, gp);

        opcode = 4'd2;
        @(posedge clk); #1;
        opcode = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            if (bus_req == 4'b0001) bus_in = (c == 1) ? 4'h6 : 4'h7;
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        chk("getb busy", {busy, bus_req}, 5'h10);
        rst_n = 1'b0;
        #1;
        chk("midrst", {bus_req, bus_out, bus_oe, done, carry, zero, busy},
            13'h0);
        #1;
        rst_n = 1'b1;
        ref_last = 4'h0;

        run_op(4'd1, 4'h7, 4'h1, 4'h0, 1'b0, 4, 1'b0, 0, 4'h0,
               d, go, goe, gc, gz, gs, gp);
        check_op("post rst", d, 5, go, 4'h8, goe, 1'b1, gc, 1'b0, gz, 1'b0,
                 gs, gp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
